countdown_timer_ctrl: RTL and testbench

//  Parametrised N-digit BCD countdown timer: FSM plus cascaded BCD down-counter and alarm output.

---
 rtl/countdown_timer_ctrl_pkg.sv | 20 ++
 rtl/countdown_timer_ctrl_bcd_digit_down.sv | 34 +++
 rtl/countdown_timer_ctrl.sv | 173 +++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the BCD countdown timer: digit width, BCD limit,
// timer state encoding and a per-nibble saturation helper.
package countdown_timer_ctrl_pkg;

   localparam int unsigned BCD_BIT_WIDTH = 4;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      TMR_IDLE,
      TMR_RUN,
      TMR_PAUSE,
      TMR_DONE
   } tmr_state_t;

   // Clamp a nibble into the legal BCD range 0..9.
   function automatic logic [BCD_BIT_WIDTH-1:0] bcd_sat(input logic [BCD_BIT_WIDTH-1:0] n);
      return (n > BCD_MAX) ? BCD_MAX : n;
   endfunction

endpackage

// File: rtl/countdown_timer_ctrl_bcd_digit_down.sv
// One BCD digit of the cascaded down-counter. Decrements when dec is set and
// every lower digit is zero (borrow_in); wraps 0 -> 9 and passes the borrow up.
module bcd_digit_down
   import countdown_timer_ctrl_pkg::*;
#(
   parameter logic [BCD_BIT_WIDTH-1:0] INIT = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     dec,
   input  logic                     borrow_in,
   input  logic                     load,
   input  logic [BCD_BIT_WIDTH-1:0] load_val,
   output logic [BCD_BIT_WIDTH-1:0] digit,
   output logic                     borrow_out
);

   // Borrow ripples upward only through digits that are currently zero.
   always_comb begin
      borrow_out = borrow_in && (digit == '0);
   end

   // Digit register: reset to its preset nibble, load beats decrement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit <= INIT;
      end else if (load) begin
         digit <= load_val;
      end else if (dec && borrow_in) begin
         digit <= (digit == '0) ? BCD_MAX : digit - 1'b1;
      end
   end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// N-digit BCD countdown timer: control FSM, reload register, alarm and
// done pulse around a chain of bcd_digit_down instances.
// Optional build macro TIMER_AUTO_RELOAD_EN: on reaching zero in RUN the
// count reloads and keeps running (a zero reload still ends in DONE).
module countdown_timer_ctrl
   import countdown_timer_ctrl_pkg::*;
#(
   parameter int unsigned                          DIGITS   = 2,
   parameter logic [BCD_BIT_WIDTH*DIGITS-1:0]      INIT_BCD = 8'h30
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             tick,
   input  logic                             start_stop,
   input  logic                             clear,
   input  logic                             load,
   input  logic [BCD_BIT_WIDTH*DIGITS-1:0]  load_val,
   output logic [BCD_BIT_WIDTH*DIGITS-1:0]  digits,
   output logic                             running,
   output logic                             done,
   output logic                             done_pulse,
   output logic                             alarm
);

   localparam int unsigned W = BCD_BIT_WIDTH * DIGITS;
   localparam logic [W-1:0] ONE_BCD = {{(W-1){1'b0}}, 1'b1};

`ifdef TIMER_AUTO_RELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif

   tmr_state_t                 state;
   logic [W-1:0]               reload;
   logic [W-1:0]               load_clean;
   logic [W-1:0]               dig_src;
   logic                       dig_load;
   logic                       dig_dec;
   logic [BCD_BIT_WIDTH-1:0]   dig_q  [DIGITS];
   logic                       borrow [DIGITS+1];

   logic ev_clear, ev_load, ev_ss, ev_tick;
   logic load_ok, cnt_zero, at_one, run_tick;

   // Resolve same-cycle pulses by priority clear > load > start_stop > tick.
   always_comb begin
      ev_clear = clear;
      ev_load  = load & ~clear;
      ev_ss    = start_stop & ~clear & ~load;
      ev_tick  = tick & ~clear & ~load & ~start_stop;
      load_ok  = ev_load && ((state == TMR_IDLE) || (state == TMR_DONE));
      at_one   = (digits == ONE_BCD);
      run_tick = ev_tick && (state == TMR_RUN) && !cnt_zero;
   end

   // Saturate each preset nibble to 9.
   always_comb begin
      load_clean = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         load_clean[i*BCD_BIT_WIDTH +: BCD_BIT_WIDTH] = bcd_sat(load_val[i*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]);
      end
   end

   // Counter control: parallel load for clear/load/auto-reload, else decrement.
   always_comb begin
      dig_load = 1'b0;
      dig_src  = reload;
      dig_dec  = 1'b0;
      if (ev_clear) begin
         dig_load = 1'b1;
      end else if (load_ok) begin
         dig_load = 1'b1;
         dig_src  = load_clean;
      end else if (run_tick) begin
         if (at_one && AUTO_RELOAD && (reload != '0)) begin
            dig_load = 1'b1;
         end else begin
            dig_dec = 1'b1;
         end
      end
   end

   // Digit 0 always sees a borrow; the borrow out of the top digit means all digits are zero.
   assign borrow[0] = 1'b1;
   assign cnt_zero  = borrow[DIGITS];

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_down #(
         .INIT (INIT_BCD[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH])
      ) u_digit (
         .clk        (clk),
         .rst_n      (rst_n),
         .dec        (dig_dec),
         .borrow_in  (borrow[g]),
         .load       (dig_load),
         .load_val   (dig_src[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
         .digit      (dig_q[g]),
         .borrow_out (borrow[g+1])
      );
   end

   // Pack the per-digit registers into the output bus.
   always_comb begin
      digits = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         digits[i*BCD_BIT_WIDTH +: BCD_BIT_WIDTH] = dig_q[i];
      end
   end

   // Control FSM with registered status outputs, reload register and alarm.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= TMR_IDLE;
         reload     <= INIT_BCD;
         running    <= 1'b0;
         done       <= 1'b0;
         done_pulse <= 1'b0;
         alarm      <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         if (ev_clear) begin
            state   <= TMR_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            alarm   <= 1'b0;
         end else if (ev_load) begin
            if (load_ok) begin
               reload  <= load_clean;
               state   <= TMR_IDLE;
               running <= 1'b0;
               done    <= 1'b0;
               alarm   <= 1'b0;
            end
         end else if (ev_ss) begin
            unique case (state)
               TMR_IDLE: begin
                  if (!cnt_zero) begin
                     state   <= TMR_RUN;
                     running <= 1'b1;
                  end else begin
                     state      <= TMR_DONE;
                     done       <= 1'b1;
                     done_pulse <= 1'b1;
                  end
               end
               TMR_RUN: begin
                  state   <= TMR_PAUSE;
                  running <= 1'b0;
               end
               TMR_PAUSE: begin
                  state   <= TMR_RUN;
                  running <= 1'b1;
               end
               default: ;
            endcase
         end else if (ev_tick) begin
            if (run_tick && at_one) begin
               done_pulse <= 1'b1;
               // A reload of zero would spin at zero, so it terminates like a normal run.
               if (!(AUTO_RELOAD && (reload != '0))) begin
                  state   <= TMR_DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
               end
            end else if (state == TMR_DONE) begin
               alarm <= ~alarm;
            end
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench for countdown_timer_ctrl (DIGITS=2, INIT_BCD=8'h30).
// Reference model tracks the count as a plain integer and the mode as a label.
module tb_countdown_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = '0;
   logic [7:0] digits;
   logic       running, done, done_pulse, alarm;

   int total = 0;
   int bad   = 0;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

`ifdef TIMER_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   int m_count, m_reload, m_mode;
   bit m_alarm, m_pulse;

   always #5 clk = ~clk;

   countdown_timer_ctrl #(
      .DIGITS   (2),
      .INIT_BCD (8'h30)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .start_stop (start_stop),
      .clear      (clear),
      .load       (load),
      .load_val   (load_val),
      .digits     (digits),
      .running    (running),
      .done       (done),
      .done_pulse (done_pulse),
      .alarm      (alarm)
   );

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'((v / 10) % 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic int preset_value(input logic [7:0] lv);
      int hi, lo;
      hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
      lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
      return hi * 10 + lo;
   endfunction

   task automatic model_reset();
      m_count  = 30;
      m_reload = 30;
      m_mode   = M_IDLE;
      m_alarm  = 1'b0;
      m_pulse  = 1'b0;
   endtask

   task automatic model_step(input logic t, input logic s, input logic c, input logic l, input logic [7:0] lv);
      m_pulse = 1'b0;
      if (c) begin
         m_mode  = M_IDLE;
         m_count = m_reload;
         m_alarm = 1'b0;
      end else if (l) begin
         if (m_mode == M_IDLE || m_mode == M_DONE) begin
            m_reload = preset_value(lv);
            m_count  = m_reload;
            m_mode   = M_IDLE;
            m_alarm  = 1'b0;
         end
      end else if (s) begin
         if (m_mode == M_IDLE) begin
            if (m_count != 0) m_mode = M_RUN;
            else begin
               m_mode  = M_DONE;
               m_pulse = 1'b1;
            end
         end else if (m_mode == M_RUN) m_mode = M_PAUSE;
         else if (m_mode == M_PAUSE) m_mode = M_RUN;
      end else if (t) begin
         if (m_mode == M_RUN) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_pulse = 1'b1;
               if (AUTO && m_reload != 0) m_count = m_reload;
               else m_mode = M_DONE;
            end
         end else if (m_mode == M_DONE) begin
            m_alarm = ~m_alarm;
         end
      end
   endtask

   task automatic check(input string tag);
      logic [7:0] e_dig;
      logic e_run, e_done, e_pulse, e_alarm;
      e_dig   = to_bcd(m_count);
      e_run   = (m_mode == M_RUN);
      e_done  = (m_mode == M_DONE);
      e_pulse = m_pulse;
      e_alarm = m_alarm;
      total++;
      assert (digits === e_dig) else begin
         bad++;
         $error("FAIL %s digits observed=%h expected=%h", tag, digits, e_dig);
      end
      total++;
      assert (running === e_run) else begin
         bad++;
         $error("FAIL %s running observed=%b expected=%b", tag, running, e_run);
      end
      total++;
      assert (done === e_done) else begin
         bad++;
         $error("FAIL %s done observed=%b expected=%b", tag, done, e_done);
      end
      total++;
      assert (done_pulse === e_pulse) else begin
         bad++;
         $error("FAIL %s done_pulse observed=%b expected=%b", tag, done_pulse, e_pulse);
      end
      total++;
      assert (alarm === e_alarm) else begin
         bad++;
         $error("FAIL %s alarm observed=%b expected=%b", tag, alarm, e_alarm);
      end
   endtask

   task automatic step(input logic t, input logic s, input logic c, input logic l, input logic [7:0] lv, input string tag);
      tick       = t;
      start_stop = s;
      clear      = c;
      load       = l;
      load_val   = lv;
      @(posedge clk);
      #1;
      tick       = 1'b0;
      start_stop = 1'b0;
      clear      = 1'b0;
      load       = 1'b0;
      model_step(t, s, c, l, lv);
      check(tag);
   endtask

   task automatic do_reset(input logic t, input string tag);
      rst_n = 1'b0;
      tick  = t;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick  = 1'b0;
      model_reset();
      check(tag);
   endtask

   initial begin
      int op;
      logic [7:0] lv;

      // Reset state.
      @(posedge clk);
      do_reset(1'b0, "reset");
      total++;
      assert (digits === 8'h30) else begin
         bad++;
         $error("FAIL reset_const digits observed=%h expected=%h", digits, 8'h30);
      end

      // Run from 30 for 11 ticks, crossing the 20 -> 19 borrow.
      step(0, 1, 0, 0, 8'h00, "start");
      for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 8'h00, "count_down");
      total++;
      assert (digits === 8'h19) else begin
         bad++;
         $error("FAIL borrow_const digits observed=%h expected=%h", digits, 8'h19);
      end

      // Reset in the middle of a count, with a tick present.
      do_reset(1'b1, "reset_midcount");

      // Run to zero from 01, then alarm toggling in DONE.
      step(0, 0, 0, 1, 8'h01, "load01");
      step(0, 1, 0, 0, 8'h00, "start01");
      step(1, 0, 0, 0, 8'h00, "reach_zero");
      step(0, 0, 0, 0, 8'h00, "pulse_end");
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h00, "alarm_tick");
      step(0, 1, 0, 0, 8'h00, "ss_in_done");
      step(1, 0, 0, 0, 8'h00, "alarm_tick2");

      // Saturating load, ignored load in RUN, pause/resume, clear in PAUSE.
      step(0, 0, 0, 1, 8'h9C, "load9C");
      step(0, 1, 0, 0, 8'h00, "start99");
      step(1, 0, 0, 0, 8'h00, "tick98");
      step(0, 0, 0, 1, 8'h12, "load_in_run");
      step(1, 1, 0, 0, 8'h00, "ss_tick_pause");
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h00, "tick_in_pause");
      step(0, 1, 0, 0, 8'h00, "resume");
      step(1, 0, 0, 0, 8'h00, "tick_resumed");
      step(0, 1, 0, 0, 8'h00, "pause_again");
      step(0, 0, 1, 0, 8'h00, "clear_pause");

      // Start with a zero count goes straight to DONE.
      step(0, 0, 0, 1, 8'h00, "load00");
      step(0, 1, 0, 0, 8'h00, "start_zero");
      step(0, 0, 0, 1, 8'hFF, "loadFF");

`ifdef TIMER_AUTO_RELOAD_EN
      // Auto reload: 30 reload, reach zero and continue running.
      step(0, 0, 0, 1, 8'h30, "ar_load30");
      step(0, 1, 0, 0, 8'h00, "ar_start");
      for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 8'h00, "ar_tick");
      step(0, 0, 1, 0, 8'h00, "ar_clear");
`endif

      // Randomised mix of pulses against the model.
      for (int n = 0; n < 600; n++) begin
         op = int'($urandom_range(0, 13));
         lv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         case (op)
            0, 1, 2, 3, 4, 5: step(1, 0, 0, 0, 8'h00, "rand_tick");
            6, 7:             step(0, 1, 0, 0, 8'h00, "rand_ss");
            8:                step(0, 0, 1, 0, 8'h00, "rand_clear");
            9:                step(0, 0, 0, 1, lv, "rand_load");
            10:               step(1, 1, 0, 0, 8'h00, "rand_ss_tick");
            11:               step(1, 0, 0, 1, lv, "rand_load_tick");
            12:               step(1, 0, 1, 0, 8'h00, "rand_clear_tick");
            default:          step(0, 0, 0, 0, 8'h00, "rand_idle");
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
